// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard by
// open-drain control of the PS/2 clock and data lines. The top level ties the
// pads as:
//   ps2_clock = clk_oe_o  ? 1'b0 : 1'bz
//   ps2_data  = data_oe_o ? 1'b0 : 1'bz
//
// Sequence:
//   1. Hold the clock low for INHIBIT_CYCLES.
//   2. Pull data low (start bit), then release the clock.
//   3. Drive bits on the device's falling edges:
//      data LSB first, odd parity, then the stop bit (line released).
//   4. Sample the device ACK on the 11th falling edge.
//   5. Wait for both lines to return high.
//
// Ports:
//   clk_i        system clock (10 MHz nominal)
//   rst_i        asynchronous reset, active high
//   tx_valid_i   request to send tx_data_i
//   tx_data_i    command byte
//   tx_ready_o   idle; tx_valid_i is accepted this cycle
//   tx_busy_o    any state other than idle (gates the PS/2 receiver)
//   tx_done_o    one-cycle pulse: byte sent and acknowledged
//   tx_error_o   one-cycle pulse: transfer failed
//   err_code_o   held until next accept: 00 ok, 01 timeout, 10 NACK
//   ps2_clk_i    raw PS/2 clock pad level (asynchronous)
//   ps2_data_i   raw PS/2 data pad level (asynchronous)
//   clk_oe_o     1 = pull PS/2 clock low
//   data_oe_o    1 = pull PS/2 data low
//
// Build option:
//   PS2_TX_RETRY_EN  When defined, a failed attempt re-enters the inhibit
//                    phase with the same byte, up to MAX_RETRIES times.
//                    tx_error_o and err_code_o report only the final failure.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES     = 1200,
  parameter int unsigned FIRST_EDGE_TIMEOUT = 150000,
  parameter int unsigned EDGE_TIMEOUT       = 20000,
  parameter int unsigned MAX_RETRIES        = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_error_o,
  output logic [1:0] err_code_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       clk_oe_o,
  output logic       data_oe_o
);

  localparam int TW = $clog2(FIRST_EDGE_TIMEOUT + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      frame_q, frame_d;   // {stop, parity, data}
  logic [3:0]      bit_q, bit_d;
  logic [IW-1:0]   inh_q, inh_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic [1:0]      err_q, err_d;

  // Pad synchronisers; the third clock stage is only used for edge detection.
  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            data_meta_q, data_sync_q;
  logic            fall;

  logic            fail_set;
  logic [1:0]      fail_code;
  logic            last_attempt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

`ifdef PS2_TX_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 2);
  logic [RW-1:0] retry_q, retry_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end

  assign last_attempt = (retry_q == RW'(MAX_RETRIES));
`else
  // Without retries the limit has no effect; every failure is final.
  localparam int unsigned max_retries_unused = MAX_RETRIES;
  assign last_attempt = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_q     <= '0;
      inh_q     <= '0;
      timer_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      inh_q     <= inh_d;
      timer_q   <= timer_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_d      = bit_q;
    inh_d      = inh_q;
    timer_d    = timer_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    err_d      = err_q;
    tx_done_o  = 1'b0;
    tx_error_o = 1'b0;
    fail_set   = 1'b0;
    fail_code  = 2'b00;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
`endif

    // Saturating down-count; states that need a fresh window reload it.
    if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          frame_d  = {1'b1, ~^tx_data_i, tx_data_i};
          err_d    = 2'b00;
          inh_d    = IW'(INHIBIT_CYCLES);
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d  = '0;
`endif
        end
      end

      INHIBIT: begin
        if (inh_q <= IW'(1)) begin
          data_oe_d = 1'b1;          // start bit
          state_d   = REQ;
        end else begin
          inh_d = inh_q - IW'(1);
        end
      end

      REQ: begin
        clk_oe_d = 1'b0;
        bit_d    = 4'd0;
        timer_d  = TW'(FIRST_EDGE_TIMEOUT);
        state_d  = SHIFT;
      end

      SHIFT: begin
        if (fall) begin
          // frame_q[9] is the stop bit (1), so index 9 releases the line.
          data_oe_d = ~frame_q[bit_q];
          timer_d   = TW'(EDGE_TIMEOUT);
          bit_d     = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = ACK;
          end
        end else if (timer_q == '0) begin
          fail_set  = 1'b1;
          fail_code = 2'b01;
        end
      end

      ACK: begin
        if (fall) begin
          if (data_sync_q) begin
            fail_set  = 1'b1;
            fail_code = 2'b10;
          end else begin
            timer_d = TW'(EDGE_TIMEOUT);
            state_d = WAIT_IDLE;
          end
        end else if (timer_q == '0) begin
          fail_set  = 1'b1;
          fail_code = 2'b01;
        end
      end

      WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          state_d = DONE;
        end else if (timer_q == '0) begin
          fail_set  = 1'b1;
          fail_code = 2'b01;
        end
      end

      DONE: begin
        tx_done_o = 1'b1;
        state_d   = IDLE;
      end

      FAIL: begin
        if (last_attempt) begin
          tx_error_o = 1'b1;
          state_d    = IDLE;
        end else begin
          inh_d    = IW'(INHIBIT_CYCLES);
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d  = retry_q + RW'(1);
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Any failure releases both lines; the code is only published when no
    // further attempt will follow.
    if (fail_set) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = FAIL;
      if (last_attempt) begin
        err_d = fail_code;
      end
    end
  end

  assign tx_ready_o = (state_q == IDLE);
  assign tx_busy_o  = (state_q != IDLE);
  assign err_code_o = err_q;
  assign clk_oe_o   = clk_oe_q;
  assign data_oe_o  = data_oe_q;

endmodule
